// File: rtl/game_pkg.sv
// Shared court geometry, fixed-point format and jump state encoding for the
// player/ball stages. Coordinates are 320x240, y-up, Q10.6 internally.
package game_pkg;

    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int FLOOR_Y    = 30;
    localparam int NET_X      = 160;
    localparam int NET_HALF_W = 6;
    localparam int FRAC_W     = 6;

    localparam int SERVE_X_P1 = 80;
    localparam int SERVE_X_P2 = 240;

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } jump_state_e;

    // Integer pixels to unsigned Q10.6.
    function automatic logic [15:0] to_q(input int px);
        return 16'(px << FRAC_W);
    endfunction

endpackage

// File: rtl/player_motion_if.sv
// Control/position bundle between the input register stage and a player
// kinematics instance.
interface player_motion_if;

    logic       frame_tick;
    logic       freeze;
    logic       round_reset;
    logic       op_move_left;
    logic       op_move_right;
    logic       op_jump;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       airborne;
    logic       jump_start;

    modport master (
        output frame_tick, freeze, round_reset, op_move_left, op_move_right, op_jump,
        input  pos_x, pos_y, airborne, jump_start
    );

    modport slave (
        input  frame_tick, freeze, round_reset, op_move_left, op_move_right, op_jump,
        output pos_x, pos_y, airborne, jump_start
    );

endinterface

// File: rtl/jump_fsm.sv
// Vertical kinematics: GROUND/RISING/FALLING state, Q4.6 velocity, Q10.6 foot
// height and landing detect. PLAYER_DOUBLE_JUMP_EN enables one air jump.
module jump_fsm
    import game_pkg::*;
#(
    parameter int JUMP_V   = 320,
    parameter int GRAVITY  = 16,
    parameter int MAX_FALL = 384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_srst,
    input  logic       i_step,
    input  logic       i_trigger,
    output logic [9:0] o_y_pix,
    output logic       o_airborne,
    output logic       o_jump_start
);

    localparam logic signed [9:0]  L_JUMP_V   = 10'(JUMP_V);
    localparam logic signed [10:0] L_NEG_MAX  = 11'sd0 - 11'(MAX_FALL);
    localparam logic signed [16:0] L_FLOOR_Q  = 17'(FLOOR_Y << FRAC_W);
    localparam logic [15:0]        L_FLOOR_UQ = to_q(FLOOR_Y);

    jump_state_e        r_state;
    logic signed [9:0]  r_vel;
    logic [15:0]        r_y_q;
    logic               r_airborne;
    logic               r_jump_start;
    logic               w_air_trig;
    logic signed [10:0] w_v_dec;
    logic signed [9:0]  w_v_next;
    logic signed [16:0] w_y_next;
    logic               w_land;

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic r_air_jump;
    assign w_air_trig = i_trigger && !r_air_jump;
`else
    assign w_air_trig = 1'b0;
`endif

    // Gravity step with fall-speed saturation and signed landing compare.
    always_comb begin
        w_v_dec = {r_vel[9], r_vel} - 11'(GRAVITY);
        if (w_v_dec < L_NEG_MAX) begin
            w_v_next = L_NEG_MAX[9:0];
        end else begin
            w_v_next = w_v_dec[9:0];
        end
        w_y_next = $signed({1'b0, r_y_q}) + $signed({{7{w_v_next[9]}}, w_v_next});
        w_land   = (w_y_next <= L_FLOOR_Q);
    end

    // Jump state machine; round_reset and async reset both abort to the floor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= GROUND;
            r_vel        <= 10'sd0;
            r_y_q        <= L_FLOOR_UQ;
            r_airborne   <= 1'b0;
            r_jump_start <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            r_air_jump   <= 1'b0;
`endif
        end else if (i_srst) begin
            r_state      <= GROUND;
            r_vel        <= 10'sd0;
            r_y_q        <= L_FLOOR_UQ;
            r_airborne   <= 1'b0;
            r_jump_start <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            r_air_jump   <= 1'b0;
`endif
        end else begin
            r_jump_start <= 1'b0;
            if (i_step) begin
                case (r_state)
                    GROUND: begin
                        if (i_trigger) begin
                            r_vel        <= L_JUMP_V;
                            r_state      <= RISING;
                            r_airborne   <= 1'b1;
                            r_jump_start <= 1'b1;
                        end
                    end
                    RISING, FALLING: begin
                        if (w_air_trig) begin
                            r_vel        <= L_JUMP_V;
                            r_state      <= RISING;
                            r_jump_start <= 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
                            r_air_jump   <= 1'b1;
`endif
                        end else if (w_land) begin
                            r_y_q      <= L_FLOOR_UQ;
                            r_vel      <= 10'sd0;
                            r_state    <= GROUND;
                            r_airborne <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
                            r_air_jump <= 1'b0;
`endif
                        end else begin
                            r_y_q <= w_y_next[15:0];
                            r_vel <= w_v_next;
                            if (r_state == RISING && w_v_next <= 10'sd0) begin
                                r_state <= FALLING;
                            end
                        end
                    end
                    default: begin
                        r_state    <= GROUND;
                        r_vel      <= 10'sd0;
                        r_y_q      <= L_FLOOR_UQ;
                        r_airborne <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_y_pix      = r_y_q[15:6];
    assign o_airborne   = r_airborne;
    assign o_jump_start = r_jump_start;

endmodule

// File: rtl/player_motion.sv
// Per-player kinematics: clamped horizontal motion, jump edge detect and the
// round_reset > freeze > frame_tick priority. Option: PLAYER_DOUBLE_JUMP_EN.
module player_motion
    import game_pkg::*;
#(
    parameter int SIDE       = 0,
    parameter int MOVE_SPEED = 3,
    parameter int JUMP_V     = 320,
    parameter int GRAVITY    = 16,
    parameter int MAX_FALL   = 384,
    parameter int HALF_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    player_motion_if.slave  bus
);

    localparam int L_X_MIN = (SIDE == 0) ? HALF_W : NET_X + NET_HALF_W + HALF_W;
    localparam int L_X_MAX = (SIDE == 0) ? NET_X - NET_HALF_W - HALF_W : SCREEN_W - 1 - HALF_W;
    localparam logic signed [16:0] L_MIN_Q   = 17'(L_X_MIN << FRAC_W);
    localparam logic signed [16:0] L_MAX_Q   = 17'(L_X_MAX << FRAC_W);
    localparam logic signed [16:0] L_STEP_Q  = 17'(MOVE_SPEED << FRAC_W);
    localparam logic [15:0]        L_SERVE_Q = to_q((SIDE == 0) ? SERVE_X_P1 : SERVE_X_P2);

    logic [15:0]        r_x_q;
    logic               r_jump_prev;
    logic               w_step;
    logic               w_trigger;
    logic signed [16:0] w_x_move;
    logic [15:0]        w_x_next;

    assign w_step    = bus.frame_tick && !bus.freeze;
    assign w_trigger = bus.op_jump && !r_jump_prev;

    // One guard bit keeps a leftward step from wrapping before the clamp.
    always_comb begin
        case ({bus.op_move_left, bus.op_move_right})
            2'b10:   w_x_move = $signed({1'b0, r_x_q}) - L_STEP_Q;
            2'b01:   w_x_move = $signed({1'b0, r_x_q}) + L_STEP_Q;
            default: w_x_move = $signed({1'b0, r_x_q});
        endcase
        if (w_x_move < L_MIN_Q) begin
            w_x_next = L_MIN_Q[15:0];
        end else if (w_x_move > L_MAX_Q) begin
            w_x_next = L_MAX_Q[15:0];
        end else begin
            w_x_next = w_x_move[15:0];
        end
    end

    // Horizontal position and jump edge history, advanced only on accepted ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_q       <= L_SERVE_Q;
            r_jump_prev <= 1'b0;
        end else if (bus.round_reset) begin
            r_x_q       <= L_SERVE_Q;
            r_jump_prev <= 1'b0;
        end else if (w_step) begin
            r_x_q       <= w_x_next;
            r_jump_prev <= bus.op_jump;
        end
    end

    jump_fsm #(
        .JUMP_V   (JUMP_V),
        .GRAVITY  (GRAVITY),
        .MAX_FALL (MAX_FALL)
    ) u_jump (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_srst       (bus.round_reset),
        .i_step       (w_step),
        .i_trigger    (w_trigger),
        .o_y_pix      (bus.pos_y),
        .o_airborne   (bus.airborne),
        .o_jump_start (bus.jump_start)
    );

    assign bus.pos_x = r_x_q[15:6];

endmodule
